// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit and the DIV unit.
// The master drives start and operands; the divider (slave) returns results and status.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for MIPS DIV: remainder to hi_out, quotient to lo_out.
// Optional macro DIV_ZERO_EXC_EN: divide-by-zero short-circuits straight to DONE with div_zero.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             sub_ok;
    logic             zero_div;
    logic             calc_last;

`ifdef DIV_ZERO_EXC_EN
    logic dz;
    always_comb zero_div = (bus.divisor == '0);
`else
    always_comb zero_div = 1'b0;
`endif

    always_comb calc_last = (count == CW'(WIDTH));

    // One restoring step; the true difference always fits in WIDTH bits when taken.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        quo_sh   = {quo[WIDTH-2:0], 1'b0};
        sub_ok   = (rem_sh >= {1'b0, dvs});
        rem_diff = rem_sh[WIDTH-1:0] - dvs;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = zero_div ? DONE : CALC;
            CALC: if (calc_last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        if (state == CALC || state == FIX) bus.busy = 1'b1;
        if (state == DONE)                 bus.done = 1'b1;
    end

`ifdef DIV_ZERO_EXC_EN
    always_comb bus.div_zero = dz && (state == DONE);
`else
    always_comb bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            count      <= '0;
            bus.hi_out <= '0;
            bus.lo_out <= '0;
`ifdef DIV_ZERO_EXC_EN
            dz         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Magnitudes are unsigned, so |0x80000000| is representable.
                        quo    <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                        dvs    <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                        sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r <= bus.dividend[WIDTH-1];
                        rem    <= '0;
                        count  <= '0;
`ifdef DIV_ZERO_EXC_EN
                        dz     <= zero_div;
`endif
                    end
                end
                CALC: begin
                    if (!calc_last) begin
                        rem   <= sub_ok ? rem_diff : rem_sh[WIDTH-1:0];
                        quo   <= {quo_sh[WIDTH-1:1], sub_ok};
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    bus.lo_out <= sign_q ? -quo : quo;
                    bus.hi_out <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Randomised bench for div_unit: plain-arithmetic reference model plus directed literal cases.
// Honours DIV_ZERO_EXC_EN the same way as the design.
module tb_div_unit;
    localparam int W = 32;
`ifdef DIV_ZERO_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    div_unit_if #(.WIDTH(W)) bus ();
    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit zx_of(input logic [W-1:0] d);
        return EXC && (d == '0);
    endfunction

    // Signed division from magnitudes; returns {remainder, quotient}.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ma, mb, q, r, qs, rs;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? longint'(-sa) : longint'(sa);
        mb = (sb < 0) ? longint'(-sb) : longint'(sb);
        if (mb == 0) begin
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        qs = (a[W-1] ^ b[W-1]) ? -q : q;
        rs = a[W-1] ? -r : r;
        return {rs[W-1:0], qs[W-1:0]};
    endfunction

    // Reference timeline: edge index of acceptance, done, and next acceptable start.
    longint         ecount    = 0;
    longint         start_e   = 0;
    longint         done_edge = 0;
    longint         free_edge = 0;
    bit             active    = 1'b0;
    bit             m_zx      = 1'b0;
    logic [W-1:0]   m_hi      = '0;
    logic [W-1:0]   m_lo      = '0;
    logic [W-1:0]   p_hi      = '0;
    logic [W-1:0]   p_lo      = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecount    <= 0;
            active    <= 1'b0;
            free_edge <= 0;
            m_hi      <= '0;
            m_lo      <= '0;
        end else begin
            ecount <= ecount + 1;
            if (bus.start && (ecount + 1 >= free_edge)) begin
                active    <= 1'b1;
                start_e   <= ecount + 1;
                m_zx      <= zx_of(bus.divisor);
                done_edge <= ecount + 1 + (zx_of(bus.divisor) ? 0 : W + 2);
                free_edge <= ecount + 1 + (zx_of(bus.divisor) ? 2 : W + 4);
                {p_hi, p_lo} <= ref_div(bus.dividend, bus.divisor);
            end
            if (active && !m_zx && (ecount + 1 == done_edge)) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end
    end

    always @(negedge clk) begin
        chk_bit("done", bus.done, active && (ecount == done_edge));
        chk_bit("busy", bus.busy, active && !m_zx && (ecount >= start_e) && (ecount < done_edge));
        chk_bit("div_zero", bus.div_zero, active && m_zx && (ecount == done_edge));
        chk("hi_out", bus.hi_out, m_hi);
        chk("lo_out", bus.lo_out, m_lo);
    end

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                           input int exp_lat, input bit exp_dz, input bit repulse,
                           input string name);
        int k;
        bit seen;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        k    = 0;
        seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clk);
            if (k == 0) begin
                bus.start    = 1'b0;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            if (repulse && k == 5) begin
                bus.start    = 1'b1;
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            if (repulse && k == 6) bus.start = 1'b0;
            if (repulse && k > 0) chk_bit({name, "_busy"}, bus.busy, !bus.done);
            if (bus.done) seen = 1'b1;
            else begin
                k++;
                @(posedge clk);
            end
        end
        chk_bit({name, "_done_seen"}, seen, 1'b1);
        chk({name, "_latency"}, W'(k), W'(exp_lat));
        chk_bit({name, "_div_zero"}, bus.div_zero, exp_dz);
        chk({name, "_lo"}, bus.lo_out, exp_lo);
        chk({name, "_hi"}, bus.hi_out, exp_hi);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'd1;
            2:       v = '1;
            3:       v = 32'h8000_0000;
            4:       v = W'($urandom_range(0, 15));
            5:       v = -W'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int ndone;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", bus.hi_out, '0);
        chk("reset_lo", bus.lo_out, '0);
        chk_bit("reset_busy", bus.busy, 1'b0);
        reset = 1'b0;

        run_div(32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001, W + 2, 1'b0, 1'b0, "div7_2");
        run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, W + 2, 1'b0, 1'b0, "divm7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, W + 2, 1'b0, 1'b0, "div7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, W + 2, 1'b0, 1'b0, "divmin_m1");
`ifdef DIV_ZERO_EXC_EN
        run_div(32'd100, 32'd0, 32'h8000_0000, 32'h0000_0000, 0, 1'b1, 1'b0, "div100_0");
`else
        run_div(32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, W + 2, 1'b0, 1'b0, "div100_0");
`endif
        run_div(32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, W + 2, 1'b0, 1'b1, "repulse");

        // Abort mid-CALC with an asynchronous reset.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd17;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_hi", bus.hi_out, '0);
        chk("abort_lo", bus.lo_out, '0);
        chk_bit("abort_busy", bus.busy, 1'b0);
        chk_bit("abort_done", bus.done, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", W'(ndone), '0);
        run_div(32'd9, 32'd3, 32'd3, 32'd0, W + 2, 1'b0, 1'b0, "div9_3");

        // Random traffic: the model decides which start pulses are accepted.
        repeat (4000) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = pick_operand();
            bus.divisor  = pick_operand();
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W + 8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
